// File: rtl/unidade_controle.sv
// Multi-cycle control unit: sequences each RISC-V instruction through
// FETCH/DECODE/EXECUTE/WRITEBACK and drives the datapath enables and ULA controls.
module unidade_controle #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [31:0]            instruction,
    output logic                   load_en,
    output logic                   store_en,
    output logic [1:0]             op_ula,
    output logic                   operation_type,
    output logic                   ula_entry,
    output logic                   pc_en,
    output logic                   busy,
    output logic                   halted,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_REG   = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;

    localparam logic [1:0] ULA_ADD = 2'b01;
    localparam logic [1:0] ULA_SUB = 2'b00;

    // Decoded control bundle, applied to the outputs at the DECODE exit edge.
    typedef struct packed {
        logic       valid;
        logic       is_store;
        logic [1:0] op;
        logic       op_type;
        logic       entry;
    } decode_t;

    state_t                   state;
    state_t                   state_next;
    logic [31:0]              instr_reg;
    logic                     wb_store;
    decode_t                  dec;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_reg[6:0];
    assign funct3 = instr_reg[14:12];
    assign funct7 = instr_reg[31:25];

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        dec = '{valid: 1'b0, is_store: 1'b0, op: ULA_ADD, op_type: 1'b0, entry: 1'b0};
        unique case (opcode)
            OPC_LOAD: begin
                if (funct3 == 3'b011) begin
                    dec = '{valid: 1'b1, is_store: 1'b0, op: ULA_ADD, op_type: 1'b0, entry: 1'b0};
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b011) begin
                    dec = '{valid: 1'b1, is_store: 1'b1, op: ULA_ADD, op_type: 1'b0, entry: 1'b0};
                end
            end
            OPC_REG: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    dec = '{valid: 1'b1, is_store: 1'b0, op: ULA_ADD, op_type: 1'b1, entry: 1'b1};
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec = '{valid: 1'b1, is_store: 1'b0, op: ULA_SUB, op_type: 1'b1, entry: 1'b1};
                end
            end
            OPC_IMM: begin
                if (funct3 == 3'b000) begin
                    dec = '{valid: 1'b1, is_store: 1'b0, op: ULA_ADD, op_type: 1'b1, entry: 1'b0};
                end else if (funct3 == 3'b010) begin
                    dec = '{valid: 1'b1, is_store: 1'b0, op: ULA_SUB, op_type: 1'b1, entry: 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:      if (start) state_next = S_FETCH;
            S_FETCH:     state_next = S_DECODE;
            S_DECODE:    state_next = dec.valid ? S_EXECUTE : S_HALT;
            S_EXECUTE:   state_next = S_WRITEBACK;
            S_WRITEBACK: state_next = stop ? S_IDLE : S_FETCH;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_IDLE;
        endcase
    end

    // NOTE: state and registered outputs use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            instr_reg      <= '0;
            wb_store       <= 1'b0;
            load_en        <= 1'b0;
            store_en       <= 1'b0;
            pc_en          <= 1'b0;
            op_ula         <= ULA_ADD;
            operation_type <= 1'b0;
            ula_entry      <= 1'b0;
            illegal        <= 1'b0;
            instr_count    <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                S_FETCH: instr_reg <= instruction;
                S_DECODE: begin
                    if (dec.valid) begin
                        op_ula         <= dec.op;
                        operation_type <= dec.op_type;
                        ula_entry      <= dec.entry;
                        wb_store       <= dec.is_store;
                    end else begin
                        // The all-zero word is a deliberate halt, not an error.
                        illegal <= (instr_reg != 32'h0);
                    end
                end
                S_EXECUTE: begin
                    load_en  <= !wb_store;
                    store_en <= wb_store;
                    pc_en    <= 1'b1;
                end
                S_WRITEBACK: begin
                    load_en     <= 1'b0;
                    store_en    <= 1'b0;
                    pc_en       <= 1'b0;
                    instr_count <= instr_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit that drives the single-cycle-style datapath (register bank, ULA, RAM, program counter, instruction memory) from the instruction word. Sits directly upstream of the datapath. It takes the current 32-bit RISC-V instruction and produces `load_en`, `store_en`, `op_ula`, `operation_type`, `ula_entry` and a PC-advance strobe. It sequences each instruction through FETCH/DECODE/EXECUTE/WRITEBACK with a start/stop handshake.

## Interface

Parameters:
- `COUNT_WIDTH`, 16: width of retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset (`reset==0` sampled at rising edge resets the block).
- `start`  in  1  begin execution; sampled only in IDLE.
- `stop`  in  1  return to IDLE after current instruction; sampled only in WRITEBACK.
- `instruction`  in  32  word from instruction memory at current PC.
- `load_en`  out  1  register-bank write enable.
- `store_en`  out  1  RAM write enable.
- `op_ula`  out  2  ULA operation: 01 add, 00 sub.
- `operation_type`  out  1  0 memory access (ULA computes address), 1 arithmetic (ULA result to register).
- `ula_entry`  out  1  ULA B operand: 1 register rs2, 0 immediate.
- `pc_en`  out  1  datapath advances PC by 4 at the edge ending this cycle.
- `busy`  out  1  high in any state except IDLE and HALT.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  high in HALT when the cause was an undecodable instruction.
- `instr_count`  out  COUNT_WIDTH  retired instructions since reset.

## Operation

- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: `start==1` → FETCH; otherwise stay in IDLE.
- FETCH → DECODE unconditionally. `instruction` is latched into an internal `instr_reg` at this edge.
- DECODE: decode `instr_reg` combinationally. At the exit edge, register `op_ula`, `operation_type` and `ula_entry`, then go to EXECUTE, or to HALT if the word is zero or illegal.
- Decode table (opcode / funct3 / funct7):
  - LD: 0000011 / 011 / – → type 0, entry 0, op 01, `load_en` in WB.
  - SD: 0100011 / 011 / – → type 0, entry 0, op 01, `store_en` in WB.
  - ADD: 0110011 / 000 / 0000000 → type 1, entry 1, op 01, `load_en`.
  - SUB: 0110011 / 000 / 0100000 → type 1, entry 1, op 00, `load_en`.
  - ADDI: 0010011 / 000 → type 1, entry 0, op 01, `load_en`.
  - SUBI: 0010011 / 010 → type 1, entry 0, op 00, `load_en`.
- HALT causes:
  - `instr_reg==32'h0`: halt sentinel, `illegal`=0.
  - Any other non-matching word: `illegal`=1.
  - In both cases no enable and no `pc_en` is asserted for that word.
- EXECUTE → WRITEBACK. On entry to WRITEBACK, the proper write enable and `pc_en` are registered high.
- WRITEBACK: the enables are high for exactly this one cycle. At the exit edge, `instr_count` increments (wraps modulo 2^COUNT_WIDTH), enables return to 0, and the state goes to IDLE if `stop==1`, else to FETCH.
- HALT: sticky. Only `reset` leaves it; `start` and `stop` are ignored.
- `start` outside IDLE and `stop` outside WRITEBACK are ignored.
- Control outputs hold their DECODE values until the next DECODE exit. They never change while an enable is high.

## Timing

- Reset (`reset==0` at an edge): state IDLE, `load_en`=`store_en`=`pc_en`=0, `op_ula`=01, `operation_type`=0, `ula_entry`=0, `busy`=`halted`=`illegal`=0, `instr_count`=0, `instr_reg`=0. Reset has priority over every other input in any state, including mid-WRITEBACK: the pending write is dropped and the count does not increment.
- Each instruction takes 4 cycles: FETCH, DECODE, EXECUTE, WRITEBACK.
- With `start` sampled at edge E0:
  - FETCH occupies E0–E1 (`instruction` is latched at E1).
  - DECODE occupies E1–E2.
  - EXECUTE occupies E2–E3; controls are valid from E2.
  - WRITEBACK occupies E3–E4, with enables high.
  - The datapath commits at E4 and the next FETCH begins at E4.
- `busy` rises at E0 and falls at the edge that enters IDLE or HALT.
- `illegal`/`halted` rise at the DECODE exit edge. At most 3 cycles separate `start` from `halted` for a bad first word.
- The datapath must gate the register write, RAM write and PC update with these enables. The PC holds whenever `pc_en`=0.

## Test plan

- Reset: hold `reset`=0 for 2 cycles with `start`=1 → all outputs at their reset values, and `busy` stays 0.
- LD x1,7(x0) = 0x00703083, `start` at E0 → op 01, type 0, entry 0 from E2. `load_en`=`pc_en`=1 only in E3–E4. `instr_count`=1 after E4.
- Program 0x01538FB3 (add), 0x41F88F33 (sub), 0x03DE3423 (sd x29,40(x28)), then 0x00000000 → per-WB controls are (1,1,01,`load_en`), (1,1,00,`load_en`), (0,0,01,`store_en`). Result: `halted`=1, `illegal`=0, `instr_count`=3, PC advanced 3 times.
- Word 0x0000007F → HALT with `illegal`=1, no enable ever high, and `pulse start` remains ignored.
- `stop`=1 during the WRITEBACK of a valid add → returns to IDLE after one commit, `busy`=0, `instr_count` +1. `start` then resumes from FETCH.
- `reset`=0 asserted during WRITEBACK of an sd → `store_en` low after that edge, `instr_count` unchanged (0), state IDLE.
